// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, opcode encodings and the
// fetch-stage state type.
package cpu_pkg;

    localparam logic [2:0] OP_LDA  = 3'b000;
    localparam logic [2:0] OP_LDI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_BR   = 3'b100;
    localparam logic [2:0] OP_ALU3 = 3'b101;
    localparam logic [2:0] OP_SW   = 3'b110;
    localparam logic [2:0] OP_LW   = 3'b111;

    localparam int unsigned OPC_MSB = 7;
    localparam int unsigned OPC_LSB = 5;
    localparam int unsigned OPR_W   = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE
    } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC adder: pc+1, or pc plus the sign-extended 5-bit branch offset.
module pc_next
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W = 8
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [OPR_W-1:0] operand,
    input  logic             take,
    output logic [PC_W-1:0]  pc_nxt
);

    logic [PC_W-1:0] step;

    always_comb begin
        step = {{(PC_W-OPR_W){operand[OPR_W-1]}}, operand};
        if (!take) begin
            step = {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    // Modulo 2^PC_W: carry out is dropped, so wrap is silent in both directions.
    assign pc_nxt = pc + step;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack,
// holds the word for the decoder and resolves branches on retirement.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       PC_W     = 8,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [7:0]       imem_rdata,
    output logic [7:0]       instruction,
    output logic             inst_valid,
    input  logic             stall,
    input  logic             brnch,
    input  logic             br_cond,
    output logic [PC_W-1:0]  pc
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc_nxt;
    logic            take;

    assign take      = brnch & br_cond;
    assign imem_addr = pc;

    pc_next #(
        .PC_W (PC_W)
    ) u_pc_next (
        .pc      (pc),
        .operand (instruction[OPR_W-1:0]),
        .take    (take),
        .pc_nxt  (pc_nxt)
    );

    // imem_req is registered alongside the state, so it rises with S_FETCH and
    // an ack in that same cycle yields a valid word one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instruction <= '0;
            imem_req    <= 1'b0;
            inst_valid  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instruction <= imem_rdata;
                        inst_valid  <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        pc         <= pc_nxt;
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder with variable ack
// latency, random stall/branch stimulus and a transaction-level PC model.
module tb_fetch_unit;

    localparam logic [7:0] RST_PC = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       imem_req, imem_ack, inst_valid, stall, brnch, br_cond;
    logic [7:0] imem_addr, imem_rdata, instruction, pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .PC_W     (8),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .inst_valid  (inst_valid),
        .stall       (stall),
        .brnch       (brnch),
        .br_cond     (br_cond),
        .pc          (pc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [256];
    logic [7:0] m_pc, m_instr;
    bit         m_idle, m_fetching, m_holding;
    int         wait_cnt, lat_mode, stall_force, retire_cnt;
    bit         rand_stall;
    bit [1:0]   ctl_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_lat();
        return (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
    endfunction

    // Called at a falling edge: compare the DUT against the model, then drive
    // the inputs for the next rising edge and advance the model accordingly.
    task automatic step();
        int off;
        bit take;
        check("imem_req", imem_req, m_fetching);
        check("inst_valid", inst_valid, m_holding);
        check("pc", pc, m_pc);
        check("imem_addr", imem_addr, m_pc);
        check("instruction", instruction, m_instr);

        imem_ack   = 1'b0;
        imem_rdata = 8'($urandom);
        stall      = 1'($urandom);
        brnch      = 1'($urandom);
        br_cond    = 1'($urandom);

        if (m_idle) begin
            imem_ack   = 1'($urandom);
            m_idle     = 1'b0;
            m_fetching = 1'b1;
            wait_cnt   = pick_lat();
        end else if (m_fetching) begin
            if (wait_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[m_pc];
                m_instr    = mem[m_pc];
                m_fetching = 1'b0;
                m_holding  = 1'b1;
            end else begin
                wait_cnt--;
            end
        end else if (m_holding) begin
            imem_ack = 1'($urandom);
            if (stall_force > 0) begin
                stall   = 1'b1;
                brnch   = stall_force[0];
                br_cond = 1'b1;
                stall_force--;
            end else if (rand_stall) begin
                stall = ($urandom_range(3, 0) == 0);
            end else begin
                stall = 1'b0;
            end
            if (!stall) begin
                if (ctl_q.size() > 0) {brnch, br_cond} = ctl_q.pop_front();
                take = brnch && br_cond;
                off  = int'(m_instr[4:0]);
                if (off > 15) off -= 32;
                m_pc       = take ? 8'(int'(m_pc) + off) : 8'(int'(m_pc) + 1);
                m_holding  = 1'b0;
                m_fetching = 1'b1;
                wait_cnt   = pick_lat();
                retire_cnt++;
            end
        end
        @(negedge clk);
    endtask

    // Asserts reset away from any clock edge and checks outputs fall at once.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", inst_valid, 1'b0);
        check("rst_pc", pc, RST_PC);
        check("rst_instr", instruction, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        m_pc        = RST_PC;
        m_instr     = 8'h00;
        m_idle      = 1'b1;
        m_fetching  = 1'b0;
        m_holding   = 1'b0;
        stall_force = 0;
        ctl_q.delete();
    endtask

    task automatic run_retires(input int n);
        int target;
        int cyc;
        target = retire_cnt + n;
        cyc    = 0;
        while (retire_cnt < target && cyc < 40 * n + 20) begin
            step();
            cyc++;
        end
        if (retire_cnt < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got %0d retires expected %0d", retire_cnt, target);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    initial begin
        imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0; brnch = 1'b0; br_cond = 1'b0;
        retire_cnt = 0; rand_stall = 1'b0; lat_mode = 0;
        fill_mem();

        // Free-run with immediate ack.
        mem[0] = 8'h21; mem[1] = 8'h42; mem[2] = 8'h63;
        do_reset();
        ctl_q = '{2'b00, 2'b00, 2'b00};
        run_retires(3);
        check("seq_pc", pc, 8'h03);
        check("seq_last", instruction, 8'h63);

        // Slow memory.
        lat_mode = 3;
        run_retires(2);

        // Taken branch at 0x10 with offset -3, then the same not taken.
        lat_mode = 0;
        mem[8'h00] = 8'h0F; mem[8'h0F] = 8'h01; mem[8'h10] = 8'h9D; mem[8'h11] = 8'h3F;
        do_reset();
        ctl_q = '{2'b11, 2'b00, 2'b11};
        run_retires(3);
        check("br_taken", imem_addr, 8'h0D);
        do_reset();
        ctl_q = '{2'b11, 2'b00, 2'b10};
        run_retires(3);
        check("br_not_taken", imem_addr, 8'h11);

        // Five stalled cycles with branch strobes, then one plain advance.
        lat_mode    = 1;
        stall_force = 5;
        ctl_q       = '{2'b00};
        run_retires(1);
        check("stall_release", pc, 8'h12);

        // Wrap upward and downward.
        lat_mode = 0;
        mem[8'h00] = 8'h9F; mem[8'hFF] = 8'h55; mem[8'h01] = 8'h9C;
        do_reset();
        ctl_q = '{2'b11, 2'b00, 2'b10, 2'b11};
        run_retires(2);
        check("wrap_up", pc, 8'h00);
        lat_mode = 3;
        run_retires(2);
        check("wrap_down", pc, 8'hFD);

        // Reset while a request is outstanding.
        step();
        step();
        check("pre_rst_req", imem_req, 1'b1);
        do_reset();
        lat_mode = 0;
        run_retires(1);

        // Random traffic with occasional resets at arbitrary points.
        fill_mem();
        lat_mode   = -1;
        rand_stall = 1'b1;
        for (int k = 0; k < 20; k++) begin
            run_retires(50);
            if ($urandom_range(3, 0) == 0) begin
                for (int j = 0; j < int'($urandom_range(3, 0)); j++) step();
                do_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
